// File: rtl/avm_copy_pkg.sv
// avm_copy_master shared types and defaults.
// Copy-engine FSM encoding and parameter defaults.
package avm_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } copy_state_t;

  localparam int unsigned DEF_STRIDE = 4;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/avm_copy_master.sv
// Avalon-MM block copy initiator.
// One word at a time: read src+i*STRIDE, then write dst+i*STRIDE.
module avm_copy_master
  import avm_copy_pkg::*;
#(
  parameter int unsigned STRIDE = DEF_STRIDE,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] nwords,
  input  logic             master_waitrequest,
  output logic [31:0]      master_address,
  output logic             master_read,
  input  logic [31:0]      master_readdata,
  input  logic             master_readdatavalid,
  output logic             master_write,
  output logic [31:0]      master_writedata
);

  copy_state_t      state_q;
  copy_state_t      state_d;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] i_q;
  logic [CNT_W-1:0] i_inc;
  logic [31:0]      wdata_q;
  logic [31:0]      base;
  logic [31:0]      off;
  logic             last;

  assign i_inc = i_q + CNT_W'(1);
  assign last  = (i_inc == n_q);
  assign off   = 32'(i_q) * 32'(STRIDE);

  // One adder shared by read and write addressing.
  assign master_address   = base + off;
  assign master_writedata = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job capture, word counter and write-data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      n_q     <= '0;
      i_q     <= '0;
      wdata_q <= '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE) && en: begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          n_q   <= nwords;
          i_q   <= '0;
        end
        (state_q == RD_WAIT) && master_readdatavalid: begin
          wdata_q <= master_readdata;
        end
        (state_q == WR_REQ) && !master_waitrequest: begin
          i_q <= i_inc;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && (nwords != '0)) state_d = RD_REQ;
      end
      RD_REQ: begin
        if (!master_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (master_readdatavalid) state_d = WR_REQ;
      end
      WR_REQ: begin
        if (!master_waitrequest) begin
          state_d = last ? IDLE : RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    rdy          = 1'b0;
    master_read  = 1'b0;
    master_write = 1'b0;
    base         = src_q;
    unique case (state_q)
      IDLE:    rdy = 1'b1;
      RD_REQ:  master_read = 1'b1;
      RD_WAIT: ;
      WR_REQ: begin
        master_write = 1'b1;
        base         = dst_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avm_copy_master.sv
// Testbench for avm_copy_master.
// Memory slave model plus an ordered-copy reference.
module tb_avm_copy_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] nwords;
  logic        wr_req_wait;
  logic [31:0] m_addr;
  logic        m_read;
  logic [31:0] m_rdata;
  logic        m_rdv;
  logic        m_write;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  avm_copy_master #(.STRIDE(4), .CNT_W(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .rdy                  (rdy),
    .src_addr             (src_addr),
    .dst_addr             (dst_addr),
    .nwords               (nwords),
    .master_waitrequest   (wr_req_wait),
    .master_address       (m_addr),
    .master_read          (m_read),
    .master_readdata      (m_rdata),
    .master_readdatavalid (m_rdv),
    .master_write         (m_write),
    .master_writedata     (m_wdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem [bit [31:0]];
  wr_t         wlog[$];
  int          rd_cnt;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave config
  int          cfg_w    = 0;
  int          cfg_lat  = 1;
  bit          cfg_spur = 1'b0;
  int          st_cnt;
  int          rsp_cnt;
  logic [31:0] rsp_data;
  bit          prev_wait;
  logic [63:0] saved_ad;
  logic [1:0]  saved_rw;

  // Memory slave: stalls cfg_w cycles per request, answers reads
  // cfg_lat cycles after acceptance, optionally injects junk valids.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_wait = 1'b0;
      m_rdv       = 1'b0;
      m_rdata     = 32'h0;
      st_cnt      = 0;
      rsp_cnt     = 0;
      prev_wait   = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("stall_addr_data", {m_addr, m_wdata}, saved_ad);
        chk("stall_rw", {62'd0, m_read, m_write}, {62'd0, saved_rw});
      end
      m_rdv   = 1'b0;
      m_rdata = 32'hCAFE_0000;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          m_rdv   = 1'b1;
          m_rdata = rsp_data;
        end
      end
      if (m_read || m_write) begin
        chk("rw_excl", {63'd0, m_read & m_write}, 64'd0);
        if (st_cnt < cfg_w) begin
          wr_req_wait = 1'b1;
          st_cnt++;
          prev_wait = 1'b1;
          saved_ad  = {m_addr, m_wdata};
          saved_rw  = {m_read, m_write};
        end else begin
          wr_req_wait = 1'b0;
          st_cnt      = 0;
          prev_wait   = 1'b0;
          if (m_read) begin
            rsp_data = mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
            rsp_cnt  = cfg_lat;
            rd_cnt++;
          end else begin
            mem[m_addr] = m_wdata;
            wlog.push_back('{m_addr, m_wdata});
          end
        end
        if (cfg_spur) begin
          m_rdv   = 1'b1;
          m_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        wr_req_wait = 1'b0;
        prev_wait   = 1'b0;
      end
    end
  end

  // Runs one copy starting at the current negedge (rdy expected high).
  task automatic run_copy(string tag, logic [31:0] s, logic [31:0] d,
                          int n, int w, int lat, bit spur, int exp_cyc);
    logic [31:0] refm [bit [31:0]];
    wr_t         exp_q[$];
    logic [31:0] a;
    logic [31:0] v;
    int          cyc;
    int          want;
    refm = mem;
    for (int k = 0; k < n; k++) begin
      a = s + 32'(k) * 32'd4;
      v = refm.exists(a) ? refm[a] : dflt(a);
      a = d + 32'(k) * 32'd4;
      refm[a] = v;
      exp_q.push_back('{a, v});
    end
    want = (exp_cyc < 0) ? n * (2 * w + 2 + lat) + 1 : exp_cyc;
    cfg_w    = w;
    cfg_lat  = lat;
    cfg_spur = spur;
    wlog.delete();
    rd_cnt   = 0;
    src_addr = s;
    dst_addr = d;
    nwords   = 16'(n);
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en       = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    nwords   = 16'($urandom);
    cyc = 1;
    while (!rdy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL %s:timeout actual=busy required=rdy", tag);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      chk({tag, ":cycles"}, 64'(cyc), 64'(want));
    end
    chk({tag, ":reads"}, 64'(rd_cnt), 64'(n));
    chk({tag, ":writes"}, 64'(wlog.size()), 64'(n));
    for (int k = 0; k < n && k < wlog.size(); k++) begin
      chk({tag, ":waddr"}, {32'd0, wlog[k].a}, {32'd0, exp_q[k].a});
      chk({tag, ":wdata"}, {32'd0, wlog[k].d}, {32'd0, exp_q[k].d});
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] s;
    logic [31:0] d;
    int          n;
    int          w;
    int          lat;
    bit          spur;
    int          cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h0;
    nwords   = 16'h0;
    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;

    tbl[0] = '{"basic",   32'h100,      32'h200, 3, 0, 1, 1'b0, 10};
    tbl[1] = '{"zero",    32'h300,      32'h400, 0, 0, 1, 1'b0, 1};
    tbl[2] = '{"stall",   32'h100,      32'h500, 1, 2, 3, 1'b0, 10};
    tbl[3] = '{"spur",    32'h100,      32'h600, 2, 0, 1, 1'b1, 7};
    tbl[4] = '{"overlap", 32'h700,      32'h704, 4, 0, 1, 1'b0, 13};
    tbl[5] = '{"wrap",    32'hFFFFFFF8, 32'h10,  3, 1, 2, 1'b0, 19};

    repeat (3) @(negedge clk);
    chk("rst_rdy",   {63'd0, rdy},     64'd1);
    chk("rst_read",  {63'd0, m_read},  64'd0);
    chk("rst_write", {63'd0, m_write}, 64'd0);
    chk("rst_addr",  {32'd0, m_addr},  64'd0);
    chk("rst_wdata", {32'd0, m_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {63'd0, rdy}, 64'd1);

    // Table vectors, started back to back.
    for (int t = 0; t < 6; t++) begin
      run_copy(tbl[t].tag, tbl[t].s, tbl[t].d, tbl[t].n,
               tbl[t].w, tbl[t].lat, tbl[t].spur, tbl[t].cyc);
    end

    // Randomized copies in a small region to provoke overlap.
    for (int r = 0; r < 25; r++) begin
      run_copy("rand",
               32'h1000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00},
               32'h1000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00},
               $urandom_range(0, 6), $urandom_range(0, 2),
               $urandom_range(1, 3), 1'($urandom_range(0, 1)), -1);
    end

    // Reset in the middle of word 2 of 4.
    cfg_w    = 0;
    cfg_lat  = 1;
    cfg_spur = 1'b0;
    src_addr = 32'h100;
    dst_addr = 32'h800;
    nwords   = 16'd4;
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy",   {63'd0, rdy},     64'd1);
    chk("mid_rst_read",  {63'd0, m_read},  64'd0);
    chk("mid_rst_write", {63'd0, m_write}, 64'd0);
    chk("mid_rst_addr",  {32'd0, m_addr},  64'd0);
    chk("mid_rst_wdata", {32'd0, m_wdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_release_rdy", {63'd0, rdy}, 64'd1);
    run_copy("after_rst", 32'hFFFFFFFC, 32'h40, 1, 0, 1, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
